// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: handles one operand bit per clock, LSB first, with the carry held in a flop.
// A start/busy/done handshake is in front; the result and flags are registered.
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bb_q;
    logic [WIDTH-1:0] sh_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             r;
    logic             c_next;
    logic [WIDTH-1:0] word;

    // The operand registers shift right, so the current bit is always at index 0.
    always_comb begin
        r      = 1'b0;
        c_next = carry_q;
        case (op_q)
            2'b00: r = a_q[0] & bb_q[0];
            2'b01: r = a_q[0] | bb_q[0];
            2'b10: begin
                r      = a_q[0] ^ bb_q[0] ^ carry_q;
                c_next = (a_q[0] & bb_q[0]) | (a_q[0] & carry_q) | (bb_q[0] & carry_q);
            end
            default: ;
        endcase
        word = {r, sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            a_q       <= '0;
            bb_q      <= '0;
            sh_q      <= '0;
            op_q      <= 2'b00;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else begin
            case (state_q)
                StRun: begin
                    a_q     <= a_q >> 1;
                    bb_q    <= bb_q >> 1;
                    sh_q    <= word;
                    carry_q <= c_next;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LastBit) begin
                        state_q   <= StDone;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= word;
                        carry_out <= (op_q == 2'b10) ? c_next : 1'b0;
                        // carry_q here is the carry into the MSB
                        overflow  <= (op_q == 2'b10) ? (carry_q ^ c_next) : 1'b0;
                        zero      <= (word == '0);
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q <= StRun;
                        busy    <= 1'b1;
                        a_q     <= a;
                        bb_q    <= b ^ {WIDTH{sub}};
                        op_q    <= op;
                        carry_q <= sub;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule
